// File: rtl/prog_clock_divider.sv
// Runtime-programmable integer clock divider.
// Divides clk_in by N in [2, 2^WIDTH-1]. clk_out is low for N-H cycles and then
// high for H cycles (H = N>>1). tick marks the last cycle of each period.
// A new divisor is held pending and only takes effect at a period boundary or
// on restart, so clk_out never produces a runt pulse.
module prog_clock_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_ack,
  output logic [WIDTH-1:0] div_cur
);

  // Divisor after reset, never below 2.
  localparam logic [WIDTH-1:0] RST_DIV =
    (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

  // 0 and 1 are not meaningful divisors; they are raised to 2 on capture so
  // div_cur can never hold a value below 2.
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    return (v < WIDTH'(2)) ? WIDTH'(2) : v;
  endfunction

  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0] pend_val, pend_val_nxt;
  logic             pend, pend_nxt;
  logic             clk_nxt, tick_nxt, apply;
  logic [WIDTH-1:0] load_val;
  logic             last;

  assign load_val = clamp(div_in);
  // cnt never exceeds div_cur-1, so an equality test marks the period end.
  assign last     = (cnt == div_cur - WIDTH'(1));

  // Next-state: restart beats everything, otherwise count when enabled.
  // clk_out and tick are derived from the next count and next divisor so
  // the registered outputs line up with the registered count.
  always_comb begin
    cnt_nxt      = cnt;
    div_nxt      = div_cur;
    pend_nxt     = pend;
    pend_val_nxt = pend_val;
    clk_nxt      = clk_out;
    tick_nxt     = 1'b0;
    apply        = 1'b0;

    if (restart) begin
      cnt_nxt = '0;
      clk_nxt = 1'b0;
      // A load in the restart cycle is newer than any pending value.
      if (div_load) begin
        div_nxt  = load_val;
        pend_nxt = 1'b0;
        apply    = 1'b1;
      end else if (pend) begin
        div_nxt  = pend_val;
        pend_nxt = 1'b0;
        apply    = 1'b1;
      end
    end else begin
      // Last write wins while a value is pending.
      if (div_load) begin
        pend_val_nxt = load_val;
        pend_nxt     = 1'b1;
      end
      if (en) begin
        if (last) begin
          cnt_nxt = '0;
          // Only a value pending from an earlier cycle is applied here; a
          // load arriving on the wrap cycle waits for the next wrap.
          if (pend) begin
            div_nxt = pend_val;
            apply   = 1'b1;
            if (!div_load) pend_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
        clk_nxt  = (cnt_nxt >= div_nxt - (div_nxt >> 1));
        tick_nxt = (cnt_nxt == div_nxt - WIDTH'(1));
      end
    end
  end

  // State and output registers; reset discards any pending divisor.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      div_ack  <= 1'b0;
      pend     <= 1'b0;
      pend_val <= RST_DIV;
      div_cur  <= RST_DIV;
    end else begin
      cnt      <= cnt_nxt;
      clk_out  <= clk_nxt;
      tick     <= tick_nxt;
      div_ack  <= apply;
      pend     <= pend_nxt;
      pend_val <= pend_val_nxt;
      div_cur  <= div_nxt;
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: a table of per-cycle stimulus with expected
// outputs, routed through an expectation queue, plus a hand-written
// asynchronous-reset sequence.
module tb_prog_clock_divider;
  localparam int WIDTH = 16;

  logic             clk_in = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0, restart = 1'b0, div_load = 1'b0;
  logic [WIDTH-1:0] div_in = '0;
  logic             clk_out, tick, div_ack;
  logic [WIDTH-1:0] div_cur;

  prog_clock_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .restart(restart),
    .div_in(div_in), .div_load(div_load), .clk_out(clk_out),
    .tick(tick), .div_ack(div_ack), .div_cur(div_cur)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic             rs, en, ld;
    logic [WIDTH-1:0] din;
    logic             ck, tk, ak;
    logic [WIDTH-1:0] dc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic rs, input logic e, input logic ld,
                              input int din, input logic ck, input logic tk,
                              input logic ak, input int dc);
    vec_t v;
    v.rs = rs; v.en = e; v.ld = ld; v.din = WIDTH'(din);
    v.ck = ck; v.tk = tk; v.ak = ak; v.dc = WIDTH'(dc);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic ck, input logic tk,
                       input logic ak, input logic [WIDTH-1:0] dc);
    checks++;
    if (clk_out !== ck || tick !== tk || div_ack !== ak || div_cur !== dc) begin
      errors++;
      $display("FAIL %s: got clk_out=%0b tick=%0b div_ack=%0b div_cur=%0d, want clk_out=%0b tick=%0b div_ack=%0b div_cur=%0d",
               name, clk_out, tick, div_ack, div_cur, ck, tk, ak, dc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    // rs en ld din | clk_out tick ack div_cur   (outputs after the edge)
    // Default N=2: alternate, tick with every high cycle.
    add(0,1,0,0, 1,1,0,2); add(0,1,0,0, 0,0,0,2);
    add(0,1,0,0, 1,1,0,2); add(0,1,0,0, 0,0,0,2);
    // Load 5, then restart: ack next cycle, low 3 / high 2.
    add(0,1,1,5, 1,1,0,2); add(1,1,0,0, 0,0,1,5);
    add(0,1,0,0, 0,0,0,5); add(0,1,0,0, 0,0,0,5);
    add(0,1,0,0, 1,0,0,5); add(0,1,0,0, 1,1,0,5);
    add(0,1,0,0, 0,0,0,5); add(0,1,0,0, 0,0,0,5); add(0,1,0,0, 0,0,0,5);
    add(0,1,0,0, 1,0,0,5); add(0,1,0,0, 1,1,0,5);
    // Load 4 on the wrap cycle: stays pending for a full period of 5.
    add(0,1,1,4, 0,0,0,5); add(0,1,0,0, 0,0,0,5); add(0,1,0,0, 0,0,0,5);
    add(0,1,0,0, 1,0,0,5); add(0,1,0,0, 1,1,0,5); add(0,1,0,0, 0,0,1,4);
    // N=4, load 7 at cnt=1: period finishes with 4, then low 4 / high 3.
    add(0,1,0,0, 0,0,0,4); add(0,1,1,7, 1,0,0,4); add(0,1,0,0, 1,1,0,4);
    add(0,1,0,0, 0,0,1,7);
    add(0,1,0,0, 0,0,0,7); add(0,1,0,0, 0,0,0,7); add(0,1,0,0, 0,0,0,7);
    add(0,1,0,0, 1,0,0,7); add(0,1,0,0, 1,0,0,7); add(0,1,0,0, 1,1,0,7);
    add(0,1,0,0, 0,0,0,7);
    // Clamp: 0 applied by restart, 1 applied at wrap, both read as 2.
    add(0,1,1,0, 0,0,0,7); add(1,1,0,0, 0,0,1,2);
    add(0,1,1,1, 1,1,0,2); add(0,1,0,0, 0,0,1,2);
    // Load 9 then 6 while frozen: only 6 lands, one ack.
    add(0,0,1,9, 0,0,0,2); add(0,0,1,6, 0,0,0,2);
    add(0,1,0,0, 1,1,0,2); add(0,1,0,0, 0,0,1,6);
    add(0,1,0,0, 0,0,0,6); add(0,1,0,0, 0,0,0,6); add(0,1,0,0, 1,0,0,6);
    // en=0 for 10 cycles mid-period (with a load): frozen, no apply.
    add(0,0,1,3, 1,0,0,6);
    for (int i = 0; i < 9; i++) add(0,0,0,0, 1,0,0,6);
    add(0,1,0,0, 1,0,0,6); add(0,1,0,0, 1,1,0,6); add(0,1,0,0, 0,0,1,3);
    // N=3: freeze on the last cycle forces tick low, then wraps.
    add(0,1,0,0, 0,0,0,3); add(0,1,0,0, 1,1,0,3);
    add(0,0,0,0, 1,0,0,3); add(0,1,0,0, 0,0,0,3);
    // Restart with load applies directly, even with en=0.
    add(1,0,1,8, 0,0,1,8); add(0,0,0,0, 0,0,0,8); add(0,1,0,0, 0,0,0,8);
    // Largest divisor.
    add(1,1,1,65535, 0,0,1,65535); add(0,1,0,0, 0,0,0,65535);

    // Reset state.
    #2 reset = 1'b0;
    #1 check("reset_state", 1'b0, 1'b0, 1'b0, WIDTH'(2));
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_in);
      restart  = vecs[i].rs;
      en       = vecs[i].en;
      div_load = vecs[i].ld;
      div_in   = vecs[i].din;
      exp_q.push_back(vecs[i]);
      @(posedge clk_in);
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), e.ck, e.tk, e.ak, e.dc);
    end

    // Async reset mid-period with a pending divisor.
    @(negedge clk_in);
    restart = 1'b1; en = 1'b1; div_load = 1'b1; div_in = WIDTH'(4);
    @(negedge clk_in);
    restart = 1'b0; div_load = 1'b1; div_in = WIDTH'(9);
    @(negedge clk_in);
    div_load = 1'b0;
    @(posedge clk_in); #1;
    check("pre_reset_high", 1'b1, 1'b0, 1'b0, WIDTH'(4));
    @(negedge clk_in); #2 reset = 1'b0;
    #1 check("async_reset", 1'b0, 1'b0, 1'b0, WIDTH'(2));
    @(negedge clk_in) reset = 1'b1;
    @(posedge clk_in); #1;
    check("post_reset_cnt1", 1'b1, 1'b1, 1'b0, WIDTH'(2));
    @(posedge clk_in); #1;
    check("pend_discarded", 1'b0, 1'b0, 1'b0, WIDTH'(2));
    @(posedge clk_in); #1;
    check("post_reset_cnt1b", 1'b1, 1'b1, 1'b0, WIDTH'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
